rf_alu_sequencer: RTL and testbench

Multi-cycle controller that executes LEGv8 R-format instructions on the existing 32×64 register file + ALU datapath (RFandALU). It accepts one 32-bit instruction at a time over a valid/ready handshake, then drives the read addresses, ALUOp/Opcode, captured result and write-back into Rd. It also arbitrates the single RF write port between instruction write-back and a host preload port.

---
 rtl/rf_alu_sequencer_if.sv | 40 ++++
 rtl/rf_alu_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_rf_alu_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_alu_sequencer_if.sv
// Instruction handshake, host preload port and RF/ALU datapath bus between the
// sequencer (slave) and its environment (master).
interface rf_alu_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              host_we;
    logic [4:0]        host_waddr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [4:0]        Read1;
    logic [4:0]        Read2;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [1:0]        ALUOp;
    logic [10:0]       Opcode;
    logic [DATA_W-1:0] ALU_Result;
    logic              Zero;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero_flag;
    logic              illegal;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output instr_valid, instr, host_we, host_waddr, host_wdata, ALU_Result, Zero,
        input  instr_ready, host_ack, Read1, Read2, WriteReg, WriteData, RegWrite,
               ALUOp, Opcode, done, result, zero_flag, illegal, instr_count
    );

    modport slave (
        input  instr_valid, instr, host_we, host_waddr, host_wdata, ALU_Result, Zero,
        output instr_ready, host_ack, Read1, Read2, WriteReg, WriteData, RegWrite,
               ALUOp, Opcode, done, result, zero_flag, illegal, instr_count
    );
endinterface

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle IDLE/READ/EXEC/WB sequencer executing LEGv8 R-format instructions
// on an external register file + ALU, sharing the RF write port with a host preload.
module rf_alu_sequencer #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    rf_alu_sequencer_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_PASS = 11'b11111000010;
    localparam logic [10:0] OP_NOR  = 11'b11101010000;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [4:0] XZR         = 5'd31;

    function automatic logic is_legal(input logic [10:0] opc);
        logic legal;
        case (opc)
            OP_AND, OP_ORR, OP_ADD, OP_SUB, OP_PASS, OP_NOR: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
        return legal;
    endfunction

    logic [1:0]        state_q,  state_d;
    logic [10:0]       opc_q,    opc_d;
    logic [4:0]        rn_q,     rn_d;
    logic [4:0]        rm_q,     rm_d;
    logic [4:0]        rd_q,     rd_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q,   zero_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic instr_ready_s;
    logic accept_s;
    logic legal_s;
    logic shamt_unused_s;

    assign shamt_unused_s = ^bus.instr[15:10];
    assign legal_s        = is_legal(opc_q);
    assign instr_ready_s  = !reset && (((state_q == S_IDLE) && !bus.host_we) || (state_q == S_WB));
    assign accept_s       = bus.instr_valid && instr_ready_s;

    // Next-state, instruction latch, result capture and retire counter.
    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        rd_d     = rd_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        if (accept_s) begin
            opc_d = bus.instr[31:21];
            rm_d  = bus.instr[20:16];
            rn_d  = bus.instr[9:5];
            rd_d  = bus.instr[4:0];
        end else begin
            opc_d = opc_q;
        end
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                result_d = bus.ALU_Result;
                zero_d   = bus.Zero;
                state_d  = S_WB;
            end
            S_WB: begin
                // Rd = XZR still retires and counts; only illegal opcodes are skipped.
                if (legal_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (accept_s) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opc_q    <= 11'd0;
            rn_q     <= 5'd0;
            rm_q     <= 5'd0;
            rd_q     <= 5'd0;
            result_q <= {DATA_W{1'b0}};
            zero_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    // Datapath control and status; all strobes held low while reset is asserted.
    always_comb begin
        bus.instr_ready = instr_ready_s;
        bus.host_ack    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.WriteReg    = 5'd0;
        bus.WriteData   = {DATA_W{1'b0}};
        bus.ALUOp       = 2'b00;
        bus.Opcode      = 11'd0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.host_we) begin
                        bus.host_ack  = 1'b1;
                        bus.RegWrite  = 1'b1;
                        bus.WriteReg  = bus.host_waddr;
                        bus.WriteData = bus.host_wdata;
                    end else begin
                        bus.host_ack  = 1'b0;
                    end
                end
                S_READ, S_EXEC: begin
                    bus.ALUOp  = ALUOP_RTYPE;
                    bus.Opcode = opc_q;
                end
                S_WB: begin
                    bus.done      = 1'b1;
                    bus.WriteReg  = rd_q;
                    bus.WriteData = result_q;
                    if (legal_s) begin
                        bus.RegWrite = (rd_q != XZR);
                        bus.ALUOp    = ALUOP_RTYPE;
                        bus.Opcode   = opc_q;
                    end else begin
                        bus.illegal  = 1'b1;
                    end
                end
                default: begin
                    bus.done = 1'b0;
                end
            endcase
        end else begin
            bus.done = 1'b0;
        end
    end

    assign bus.Read1       = rn_q;
    assign bus.Read2       = rm_q;
    assign bus.result      = result_q;
    assign bus.zero_flag   = zero_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Scoreboard bench: behavioural 32x64 RF + ALU around the sequencer, expected
// results queued at accept time and compared when done pulses.
module tb_rf_alu_sequencer;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_PASS = 11'b11111000010;
    localparam logic [10:0] OP_NOR  = 11'b11101010000;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PAT5    = 64'h5555_5555_5555_5555;
    localparam logic [63:0] PATA    = 64'hAAAA_AAAA_AAAA_AAAA;

    typedef struct {
        logic [63:0] res;
        logic        zf;
        logic        ill;
        logic        wr;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] ref_cnt = 16'd0;
    logic [63:0] rf   [32] = '{default: 64'd0};
    logic [63:0] refr [32] = '{default: 64'd0};
    exp_t        sb[$];

    rf_alu_sequencer_if #(.DATA_W(64), .CNT_W(16)) bus ();

    rf_alu_sequencer #(.DATA_W(64), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic is_legal(input logic [10:0] opc);
        return (opc == OP_AND) || (opc == OP_ORR) || (opc == OP_ADD) ||
               (opc == OP_SUB) || (opc == OP_PASS) || (opc == OP_NOR);
    endfunction

    function automatic logic [63:0] alu_f(input logic [1:0] op, input logic [10:0] opc,
                                          input logic [63:0] a, input logic [63:0] b);
        if (op != 2'b10) return a + b;
        case (opc)
            OP_AND:  return a & b;
            OP_ORR:  return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_PASS: return b;
            OP_NOR:  return ~(a | b);
            default: return 64'd0;
        endcase
    endfunction

    assign bus.ALU_Result = alu_f(bus.ALUOp, bus.Opcode, rf[bus.Read1], rf[bus.Read2]);
    assign bus.Zero       = (bus.ALU_Result == 64'd0);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && bus.RegWrite) rf[bus.WriteReg] <= bus.WriteData;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        #3;
        if (!reset) begin
            if (bus.RegWrite) chk("rw_ctx", 64'(bus.host_ack | bus.done), 64'd1);
            if (bus.done) begin
                chk("done_queued", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("latency",   64'(cyc),           64'(e.cyc));
                    chk("result",    bus.result,         e.res);
                    chk("zero_flag", 64'(bus.zero_flag), 64'(e.zf));
                    chk("illegal",   64'(bus.illegal),   64'(e.ill));
                    chk("regwrite",  64'(bus.RegWrite),  64'(e.wr));
                    if (e.wr) begin
                        chk("wreg",  64'(bus.WriteReg),  64'(e.rd));
                        chk("wdata", bus.WriteData,      e.res);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [10:0] opc, input logic [4:0] rm,
                            input logic [4:0] rn, input logic [4:0] rd);
        exp_t e;
        e.res = alu_f(2'b10, opc, refr[rn], refr[rm]);
        e.zf  = (e.res == 64'd0);
        e.ill = !is_legal(opc);
        e.wr  = is_legal(opc) && (rd != 5'd31);
        e.rd  = rd;
        e.cyc = cyc + 3;
        sb.push_back(e);
        if (e.wr) refr[rd] = e.res;
        if (!e.ill) ref_cnt = ref_cnt + 16'd1;
    endtask

    task automatic issue(input logic [10:0] opc, input logic [4:0] rm,
                         input logic [4:0] rn, input logic [4:0] rd);
        int n = 0;
        @(negedge clock);
        bus.instr_valid = 1'b1;
        bus.instr       = {opc, rm, 6'd0, rn, rd};
        #1;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("accept", 64'(bus.instr_ready), 64'd1);
        push_exp(opc, rm, rn, rd);
        @(posedge clock);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clock);
            #4;
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(negedge clock);
        #4;
        chk("count", 64'(bus.instr_count), 64'(ref_cnt));
    endtask

    task automatic host_write(input logic [4:0] a, input logic [63:0] d);
        @(negedge clock);
        bus.host_we    = 1'b1;
        bus.host_waddr = a;
        bus.host_wdata = d;
        #1;
        chk("host_ack",   64'(bus.host_ack),    64'd1);
        chk("host_rw",    64'(bus.RegWrite),    64'd1);
        chk("host_ready", 64'(bus.instr_ready), 64'd0);
        refr[a] = d;
        @(posedge clock);
        #1;
        bus.host_we = 1'b0;
        #1;
        chk("host_ack_pulse", 64'(bus.host_ack), 64'd0);
        chk("host_data",      rf[a],             d);
    endtask

    task automatic check_reset_outs();
        chk("rst_regwrite", 64'(bus.RegWrite),    64'd0);
        chk("rst_done",     64'(bus.done),        64'd0);
        chk("rst_illegal",  64'(bus.illegal),     64'd0);
        chk("rst_host_ack", 64'(bus.host_ack),    64'd0);
        chk("rst_ready",    64'(bus.instr_ready), 64'd0);
        chk("rst_result",   bus.result,           64'd0);
        chk("rst_zf",       64'(bus.zero_flag),   64'd0);
        chk("rst_count",    64'(bus.instr_count), 64'd0);
        chk("rst_read",     64'({bus.Read1, bus.Read2, bus.WriteReg}), 64'd0);
        chk("rst_wdata",    bus.WriteData,        64'd0);
        chk("rst_alu",      64'({bus.ALUOp, bus.Opcode}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] saved6;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.host_we     = 1'b0;
        bus.host_waddr  = 5'd0;
        bus.host_wdata  = 64'd0;
        repeat (2) @(negedge clock);
        check_reset_outs();
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(bus.instr_ready), 64'd1);

        host_write(5'd5, PAT5);
        host_write(5'd10, PATA);

        issue(OP_ADD, 5'd10, 5'd5, 5'd1);
        issue(OP_SUB, 5'd5, 5'd5, 5'd2);
        drain();
        chk("x1_add", rf[1], ONES);
        chk("x2_sub", rf[2], 64'd0);
        chk("count_2", 64'(bus.instr_count), 64'd2);

        issue(OP_ORR, 5'd2, 5'd1, 5'd7);
        drain();
        chk("x7_orr_readback", rf[7], ONES);

        issue(OP_AND,  5'd10, 5'd5, 5'd8);
        issue(OP_ORR,  5'd10, 5'd5, 5'd9);
        issue(OP_NOR,  5'd10, 5'd5, 5'd11);
        issue(OP_PASS, 5'd10, 5'd5, 5'd12);
        drain();
        chk("x8_and",  rf[8],  64'd0);
        chk("x9_orr",  rf[9],  ONES);
        chk("x11_nor", rf[11], 64'd0);
        chk("x12_pass", rf[12], PATA);

        issue(OP_ADD, 5'd10, 5'd5, 5'd31);
        drain();
        chk("xzr_kept", rf[31], 64'd0);

        issue(11'd0, 5'd10, 5'd5, 5'd14);
        drain();
        chk("illegal_nowrite", rf[14], 64'd0);

        issue(OP_ADD, 5'd5, 5'd5, 5'd3);
        issue(OP_ADD, 5'd3, 5'd3, 5'd4);
        drain();
        chk("x4_chain", rf[4], 64'h5555_5555_5555_5554);

        saved6 = refr[6];
        issue(OP_ADD, 5'd10, 5'd5, 5'd6);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outs();
        sb.delete();
        refr[6] = saved6;
        ref_cnt = 16'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("ready_after_abort", 64'(bus.instr_ready), 64'd1);
        repeat (3) @(negedge clock);
        chk("x6_aborted", rf[6], 64'd0);
        chk("count_aborted", 64'(bus.instr_count), 64'd0);

        @(negedge clock);
        bus.host_we     = 1'b1;
        bus.host_waddr  = 5'd15;
        bus.host_wdata  = 64'h0123_4567_89AB_CDEF;
        bus.instr_valid = 1'b1;
        bus.instr       = {OP_ADD, 5'd10, 6'd0, 5'd5, 5'd16};
        #1;
        chk("both_host_ack", 64'(bus.host_ack),    64'd1);
        chk("both_ready",    64'(bus.instr_ready), 64'd0);
        refr[15] = 64'h0123_4567_89AB_CDEF;
        @(posedge clock);
        #1;
        bus.host_we = 1'b0;
        @(negedge clock);
        #1;
        chk("both_ready_next", 64'(bus.instr_ready), 64'd1);
        push_exp(OP_ADD, 5'd10, 5'd5, 5'd16);
        @(posedge clock);
        #1;
        bus.instr_valid = 1'b0;
        drain();
        chk("x15_host", rf[15], 64'h0123_4567_89AB_CDEF);
        chk("x16_after_host", rf[16], ONES);

        host_write(5'd5, 64'd0);
        host_write(5'd10, 64'd0);
        issue(OP_NOR, 5'd10, 5'd5, 5'd13);
        drain();
        chk("x13_nor_zero", rf[13], ONES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
